regwr_arbiter: RTL and testbench

REGWR_ARBITER -- requirements
Module: regwr_arbiter

---
 rtl/regwr_arbiter.sv | 132 +++++++++++++
 tb/tb_regwr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regwr_arbiter.sv
// Register-file writeback arbiter.
// Merges ALU and memory-load writeback requests onto a single registered
// register-file write port. Round-robin arbitration applies only when both
// requesters collide. A clear request runs an 8-write sweep of CLR_VAL to
// R0..R7, and the same sweep runs after every reset.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_dr/alu_data     ALU writeback request
//   alu_ready                     ALU request accepted this cycle (comb)
//   mem_valid/mem_dr/mem_data     memory-load writeback request
//   mem_ready                     memory request accepted this cycle (comb)
//   clr_req                       start a full clear sweep
//   busy                          clear sweep in progress (comb)
//   Write/dr/dr_in                registered register-file write port
module regwr_arbiter #(
    parameter logic [15:0] CLR_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [2:0]  alu_dr,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [2:0]  mem_dr,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        clr_req,
    output logic        busy,
    output logic        Write,
    output logic [2:0]  dr,
    output logic [15:0] dr_in
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic                rr, rr_next;     // 0: MEM favoured, 1: ALU favoured
    logic                write_next;
    logic [IDX_W-1:0]    dr_next;
    logic [DATA_W-1:0]   dr_in_next;

    // Next-state, grant and write-port computation
    always_comb begin
        state_next = state;
        idx_next   = idx;
        rr_next    = rr;
        write_next = 1'b0;
        dr_next    = dr;
        dr_in_next = dr_in;
        alu_ready  = 1'b0;
        mem_ready  = 1'b0;
        busy       = 1'b0;

        if (rst) begin
            // Readys held low and busy high while reset is asserted
            busy = 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    busy       = 1'b1;
                    write_next = 1'b1;
                    dr_next    = idx;
                    dr_in_next = CLR_VAL;
                    idx_next   = idx + IDX_W'(1);
                    if (idx == IDX_W'(7)) begin
                        state_next = ARB;
                    end
                end
                ARB: begin
                    if (clr_req) begin
                        state_next = CLEAR;
                        idx_next   = '0;
                    end else begin
                        if (alu_valid && mem_valid) begin
                            alu_ready = rr;
                            mem_ready = ~rr;
                        end else begin
                            alu_ready = alu_valid;
                            mem_ready = mem_valid;
                        end

                        // rr moves only when the grant resolved a collision
                        if (alu_ready) begin
                            write_next = 1'b1;
                            dr_next    = alu_dr;
                            dr_in_next = alu_data;
                            if (mem_valid) begin
                                rr_next = 1'b0;
                            end
                        end else if (mem_ready) begin
                            write_next = 1'b1;
                            dr_next    = mem_dr;
                            dr_in_next = mem_data;
                            if (alu_valid) begin
                                rr_next = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
            rr    <= 1'b0;
            Write <= 1'b0;
            dr    <= '0;
            dr_in <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            rr    <= rr_next;
            Write <= write_next;
            dr    <= dr_next;
            dr_in <= dr_in_next;
        end
    end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed self-checking bench for regwr_arbiter.
// Inputs change on the falling edge; registered outputs are sampled at the
// falling edge, combinational readys 1 time unit after inputs change.
module tb_regwr_arbiter;

    localparam logic [15:0] CLR = 16'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_dr = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_dr = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        clr_req = 1'b0;
    logic        busy;
    logic        Write;
    logic [2:0]  dr;
    logic [15:0] dr_in;

    int checks   = 0;
    int failures = 0;

    regwr_arbiter #(.CLR_VAL(CLR)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dr(alu_dr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data), .mem_ready(mem_ready),
        .clr_req(clr_req), .busy(busy), .Write(Write), .dr(dr), .dr_in(dr_in)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (Write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0b exp=0", Write); end
        checks++; if (dr !== 3'd0) begin failures++; $display("FAIL rst_dr got=%0d exp=0", dr); end
        checks++; if (dr_in !== 16'd0) begin failures++; $display("FAIL rst_dr_in got=%0h exp=0", dr_in); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        checks++; if ({alu_ready, mem_ready} !== 2'b00) begin failures++; $display("FAIL rst_readys got=%b exp=00", {alu_ready, mem_ready}); end
        alu_valid = 1'b0; mem_valid = 1'b0; rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (Write !== 1'b1) begin failures++; $display("FAIL sweep_write i=%0d got=%0b exp=1", i, Write); end
            checks++; if (dr !== 3'(i)) begin failures++; $display("FAIL sweep_dr got=%0d exp=%0d", dr, i); end
            checks++; if (dr_in !== CLR) begin failures++; $display("FAIL sweep_dr_in i=%0d got=%0h exp=%0h", i, dr_in, CLR); end
            checks++; if (busy !== (i != 7)) begin failures++; $display("FAIL sweep_busy i=%0d got=%0b exp=%0b", i, busy, (i != 7)); end
            checks++; if ({alu_ready, mem_ready} !== 2'b00) begin failures++; $display("FAIL sweep_readys i=%0d got=%b exp=00", i, {alu_ready, mem_ready}); end
        end
        @(negedge clk);
        checks++; if (Write !== 1'b0) begin failures++; $display("FAIL post_sweep_write got=%0b exp=0", Write); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_sweep_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_dr = 3'd3; alu_data = 16'd23;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b10) begin failures++; $display("FAIL alu1_readys got=%b exp=10", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if (Write !== 1'b1) begin failures++; $display("FAIL alu1_write got=%0b exp=1", Write); end
        checks++; if (dr !== 3'd3) begin failures++; $display("FAIL alu1_dr got=%0d exp=3", dr); end
        checks++; if (dr_in !== 16'd23) begin failures++; $display("FAIL alu1_dr_in got=%0d exp=23", dr_in); end
        alu_valid = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL alu1_ready_drop got=%0b exp=0", alu_ready); end
        @(negedge clk);
        checks++; if (Write !== 1'b0) begin failures++; $display("FAIL alu1_idle_write got=%0b exp=0", Write); end
        checks++; if ({dr, dr_in} !== {3'd3, 16'd23}) begin failures++; $display("FAIL alu1_hold got=%0d/%0d exp=3/23", dr, dr_in); end
    endtask

    task automatic test_mem_single();
        mem_valid = 1'b1; mem_dr = 3'd5; mem_data = 16'hBEEF;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b01) begin failures++; $display("FAIL mem1_readys got=%b exp=01", {alu_ready, mem_ready}); end
        @(negedge clk);
        mem_valid = 1'b0;
        checks++; if ({Write, dr, dr_in} !== {1'b1, 3'd5, 16'hBEEF}) begin failures++; $display("FAIL mem1_write got=%0b/%0d/%0h exp=1/5/beef", Write, dr, dr_in); end
        @(negedge clk);
        checks++; if (Write !== 1'b0) begin failures++; $display("FAIL mem1_idle_write got=%0b exp=0", Write); end
    endtask

    // Both requesters target R7: MEM first (rr=0), then ALU; ALU data is final
    task automatic test_both_same_dr();
        mem_valid = 1'b1; mem_dr = 3'd7; mem_data = 16'd5;
        alu_valid = 1'b1; alu_dr = 3'd7; alu_data = 16'd9;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b01) begin failures++; $display("FAIL both_first_grant got=%b exp=01", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({Write, dr, dr_in} !== {1'b1, 3'd7, 16'd5}) begin failures++; $display("FAIL both_first_write got=%0b/%0d/%0d exp=1/7/5", Write, dr, dr_in); end
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b10) begin failures++; $display("FAIL both_second_grant got=%b exp=10", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({Write, dr, dr_in} !== {1'b1, 3'd7, 16'd9}) begin failures++; $display("FAIL both_second_write got=%0b/%0d/%0d exp=1/7/9", Write, dr, dr_in); end
        mem_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        checks++; if ({Write, dr_in} !== {1'b0, 16'd9}) begin failures++; $display("FAIL both_final got=%0b/%0d exp=0/9", Write, dr_in); end
    endtask

    // rr only moves on collision grants; single grants leave it alone
    task automatic test_rr_update();
        mem_valid = 1'b1; mem_dr = 3'd1; mem_data = 16'h0011;
        alu_valid = 1'b1; alu_dr = 3'd2; alu_data = 16'h0022;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b01) begin failures++; $display("FAIL rr_a_grant got=%b exp=01", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({dr, dr_in} !== {3'd1, 16'h0011}) begin failures++; $display("FAIL rr_a_write got=%0d/%0h exp=1/11", dr, dr_in); end
        mem_valid = 1'b0;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b10) begin failures++; $display("FAIL rr_b_grant got=%b exp=10", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({Write, dr, dr_in} !== {1'b1, 3'd2, 16'h0022}) begin failures++; $display("FAIL rr_b_write got=%0b/%0d/%0h exp=1/2/22", Write, dr, dr_in); end
        mem_valid = 1'b1; mem_dr = 3'd5; mem_data = 16'h0055;
        alu_dr = 3'd6; alu_data = 16'h0066;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b10) begin failures++; $display("FAIL rr_c_grant got=%b exp=10", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({dr, dr_in} !== {3'd6, 16'h0066}) begin failures++; $display("FAIL rr_c_write got=%0d/%0h exp=6/66", dr, dr_in); end
        alu_dr = 3'd3; alu_data = 16'h0077;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b01) begin failures++; $display("FAIL rr_d_grant got=%b exp=01", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({dr, dr_in} !== {3'd5, 16'h0055}) begin failures++; $display("FAIL rr_d_write got=%0d/%0h exp=5/55", dr, dr_in); end
        mem_valid = 1'b0;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b10) begin failures++; $display("FAIL rr_e_grant got=%b exp=10", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({dr, dr_in} !== {3'd3, 16'h0077}) begin failures++; $display("FAIL rr_e_write got=%0d/%0h exp=3/77", dr, dr_in); end
        alu_valid = 1'b0;
        @(negedge clk);
        checks++; if (Write !== 1'b0) begin failures++; $display("FAIL rr_idle_write got=%0b exp=0", Write); end
    endtask

    task automatic test_clear();
        clr_req = 1'b1; alu_valid = 1'b1; alu_dr = 3'd2; alu_data = 16'h0BEE;
        #1;
        checks++; if ({alu_ready, mem_ready} !== 2'b00) begin failures++; $display("FAIL clr_readys got=%b exp=00", {alu_ready, mem_ready}); end
        @(negedge clk);
        checks++; if ({busy, Write} !== 2'b10) begin failures++; $display("FAIL clr_enter got=%b exp=10", {busy, Write}); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 6) clr_req = 1'b0;
            #1;
            checks++; if ({Write, dr, dr_in} !== {1'b1, 3'(i), CLR}) begin failures++; $display("FAIL clr_sweep i=%0d got=%0b/%0d/%0h", i, Write, dr, dr_in); end
            checks++; if (alu_ready !== (i == 7)) begin failures++; $display("FAIL clr_alu_ready i=%0d got=%0b exp=%0b", i, alu_ready, (i == 7)); end
        end
        @(negedge clk);
        checks++; if ({Write, dr, dr_in} !== {1'b1, 3'd2, 16'h0BEE}) begin failures++; $display("FAIL clr_alu_write got=%0b/%0d/%0h exp=1/2/bee", Write, dr, dr_in); end
        alu_valid = 1'b0;
        @(negedge clk);
        checks++; if (Write !== 1'b0) begin failures++; $display("FAIL clr_idle_write got=%0b exp=0", Write); end
    endtask

    task automatic test_reset_mid_sweep();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({Write, dr} !== {1'b1, 3'(i)}) begin failures++; $display("FAIL mid_pre i=%0d got=%0b/%0d", i, Write, dr); end
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({Write, dr, dr_in, busy} !== {1'b0, 3'd0, 16'd0, 1'b1}) begin failures++; $display("FAIL mid_rst i=%0d got=%0b/%0d/%0h/%0b exp=0/0/0/1", i, Write, dr, dr_in, busy); end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if ({Write, dr} !== {1'b1, 3'(i)}) begin failures++; $display("FAIL mid_post i=%0d got=%0b/%0d exp=1/%0d", i, Write, dr, i); end
        end
        @(negedge clk);
        checks++; if ({Write, busy} !== 2'b00) begin failures++; $display("FAIL mid_done got=%b exp=00", {Write, busy}); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_mem_single();
        test_both_same_dr();
        test_rr_update();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

endmodule
